// File: rtl/hazard_forward_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit_pkg
//
// Shared definitions for the hazard/forwarding unit and the EX-stage operand
// muxes it steers. The select encoding lives here so the unit and the mux
// instantiation agree on it by construction.
//
// Contents:
//   REG_W_DEFAULT  default register-address width (5 -> 32 registers)
//   CNT_W_DEFAULT  default load-use stall counter width
//   fwd_sel_e      4-way EX operand mux select codes (2'b11 is never driven)
//   OPER_A/OPER_B  operand indices used by the per-operand comparator array
// ---------------------------------------------------------------------------
package hazard_forward_unit_pkg;

    localparam int REG_W_DEFAULT = 5;
    localparam int CNT_W_DEFAULT = 16;

    // Operand mux select codes. 2'b11 is reserved for a future source.
    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,  // value read from the register file in ID
        FWD_EXMEM = 2'b01,  // result held in the EX/MEM pipeline register
        FWD_MEMWB = 2'b10   // result held in the MEM/WB pipeline register
    } fwd_sel_e;

    // Two EX operands: A is fed from rs, B from rt.
    localparam int NUM_OPERANDS = 2;
    localparam int OPER_A       = 0;
    localparam int OPER_B       = 1;

endpackage : hazard_forward_unit_pkg

// File: rtl/hazard_forward_unit_fwd_compare.sv
// ---------------------------------------------------------------------------
// fwd_compare
//
// Forwarding decision for a single EX operand. Compares the operand's source
// register against the destinations of the instructions currently in MEM and
// WB and picks the youngest producer. Purely combinational.
//
// Ports:
//   src_i            source register of the operand for the instruction in EX
//   uses_i           EX instruction actually reads this operand
//   mem_dest_i       destination register of the instruction in MEM
//   mem_reg_write_i  instruction in MEM writes a register
//   wb_dest_i        destination register of the instruction in WB
//   wb_reg_write_i   instruction in WB writes a register
//   sel_o            operand mux select (FWD_RF / FWD_EXMEM / FWD_MEMWB)
// ---------------------------------------------------------------------------
module fwd_compare
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT
) (
    input  logic [REG_W-1:0] src_i,
    input  logic             uses_i,
    input  logic [REG_W-1:0] mem_dest_i,
    input  logic             mem_reg_write_i,
    input  logic [REG_W-1:0] wb_dest_i,
    input  logic             wb_reg_write_i,
    output fwd_sel_e         sel_o
);

    logic mem_hit;
    logic wb_hit;

    // Register 0 is hard-wired to zero, so a "write" to it must never be
    // forwarded even though the producer asserts reg_write.
    assign mem_hit = uses_i && mem_reg_write_i &&
                     (mem_dest_i != '0) && (mem_dest_i == src_i);
    assign wb_hit  = uses_i && wb_reg_write_i &&
                     (wb_dest_i != '0) && (wb_dest_i == src_i);

    // MEM holds the younger of the two producers, so it wins when both match.
    always_comb begin
        sel_o = FWD_RF;
        if (mem_hit) begin
            sel_o = FWD_EXMEM;
        end else if (wb_hit) begin
            sel_o = FWD_MEMWB;
        end
    end

endmodule : fwd_compare

// File: rtl/hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// hazard_forward_unit
//
// Data-hazard forwarding and load-use / branch hazard control for a classic
// five-stage pipeline. The unit keeps its own shadow copy of the hazard-
// relevant fields of the instructions in EX, MEM and WB, fed from the ID
// stage fields each cycle, so it needs no taps into the datapath registers.
//
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   id_rs, id_rt               source registers of the instruction in ID
//   id_uses_rs, id_uses_rt     ID instruction reads rs / rt
//   id_dest                    destination register of the ID instruction
//   id_reg_write, id_mem_read  ID instruction writes a register / is a load
//   ex_branch_taken            branch resolved taken in EX this cycle
//   fwd_a_sel, fwd_b_sel       EX operand A / B mux selects (zero latency)
//   stall_if_id                hold PC and IF/ID this cycle
//   flush_if_id                zero IF/ID at the next edge
//   flush_id_ex                load a bubble into ID/EX at the next edge
//   stall_count                saturating count of load-use stall cycles
// ---------------------------------------------------------------------------
module hazard_forward_unit
    import hazard_forward_unit_pkg::*;
#(
    parameter int REG_W = REG_W_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,

    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             ex_branch_taken,

    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall_if_id,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic [CNT_W-1:0] stall_count
);

    // -----------------------------------------------------------------------
    // Shadow pipeline state
    // -----------------------------------------------------------------------
    // EX stage: everything needed for operand forwarding and load-use checks.
    logic [REG_W-1:0] ex_rs_q,        ex_rs_d;
    logic [REG_W-1:0] ex_rt_q,        ex_rt_d;
    logic             ex_uses_rs_q,   ex_uses_rs_d;
    logic             ex_uses_rt_q,   ex_uses_rt_d;
    logic [REG_W-1:0] ex_dest_q,      ex_dest_d;
    logic             ex_reg_write_q, ex_reg_write_d;
    logic             ex_mem_read_q,  ex_mem_read_d;

    // MEM and WB stages only matter as producers.
    logic [REG_W-1:0] mem_dest_q,      mem_dest_d;
    logic             mem_reg_write_q, mem_reg_write_d;
    logic [REG_W-1:0] wb_dest_q,       wb_dest_d;
    logic             wb_reg_write_q,  wb_reg_write_d;

    logic [CNT_W-1:0] stall_count_q,   stall_count_d;

    // -----------------------------------------------------------------------
    // Hazard detection
    // -----------------------------------------------------------------------
    logic ex_load_nz;
    logic rs_load_hit;
    logic rt_load_hit;
    logic load_use;

    // A load into r0 produces nothing a consumer can depend on.
    assign ex_load_nz  = ex_mem_read_q && (ex_dest_q != '0);
    assign rs_load_hit = id_uses_rs && (id_rs == ex_dest_q);
    assign rt_load_hit = id_uses_rt && (id_rt == ex_dest_q);
    assign load_use    = ex_load_nz && (rs_load_hit || rt_load_hit);

    // A taken branch squashes the dependent instruction in ID anyway, so the
    // stall is pointless and suppressed; the bubble into EX happens either way.
    assign stall_if_id = load_use && !ex_branch_taken;
    assign flush_if_id = ex_branch_taken;
    assign flush_id_ex = load_use || ex_branch_taken;

    // -----------------------------------------------------------------------
    // Operand forwarding: one comparator per EX operand
    // -----------------------------------------------------------------------
    logic [REG_W-1:0] ex_src  [NUM_OPERANDS];
    logic             ex_uses [NUM_OPERANDS];
    fwd_sel_e         fwd_sel [NUM_OPERANDS];

    assign ex_src[OPER_A]  = ex_rs_q;
    assign ex_src[OPER_B]  = ex_rt_q;
    assign ex_uses[OPER_A] = ex_uses_rs_q;
    assign ex_uses[OPER_B] = ex_uses_rt_q;

    generate
        for (genvar gi = 0; gi < NUM_OPERANDS; gi++) begin : g_fwd
            fwd_compare #(
                .REG_W (REG_W)
            ) u_fwd_compare (
                .src_i           (ex_src[gi]),
                .uses_i          (ex_uses[gi]),
                .mem_dest_i      (mem_dest_q),
                .mem_reg_write_i (mem_reg_write_q),
                .wb_dest_i       (wb_dest_q),
                .wb_reg_write_i  (wb_reg_write_q),
                .sel_o           (fwd_sel[gi])
            );
        end
    endgenerate

    assign fwd_a_sel   = fwd_sel[OPER_A];
    assign fwd_b_sel   = fwd_sel[OPER_B];
    assign stall_count = stall_count_q;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // ID -> EX, replaced by an all-zero bubble when ID/EX is flushed.
        // During a stall the front end holds IF/ID, so the same ID fields are
        // presented again next cycle and enter EX behind the bubble.
        ex_rs_d        = id_rs;
        ex_rt_d        = id_rt;
        ex_uses_rs_d   = id_uses_rs;
        ex_uses_rt_d   = id_uses_rt;
        ex_dest_d      = id_dest;
        ex_reg_write_d = id_reg_write;
        ex_mem_read_d  = id_mem_read;
        if (flush_id_ex) begin
            ex_rs_d        = '0;
            ex_rt_d        = '0;
            ex_uses_rs_d   = 1'b0;
            ex_uses_rt_d   = 1'b0;
            ex_dest_d      = '0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
        end

        // EX -> MEM -> WB always advance; the back end never stalls.
        mem_dest_d      = ex_dest_q;
        mem_reg_write_d = ex_reg_write_q;
        wb_dest_d       = mem_dest_q;
        wb_reg_write_d  = mem_reg_write_q;

        // Count only stalls that actually happen (not branch-cancelled ones),
        // holding at all-ones rather than wrapping.
        stall_count_d = stall_count_q;
        if (stall_if_id && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // State registers. Clearing EX on reset also cancels any stall in
    // progress, since load_use depends only on EX state.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_rs_q         <= '0;
            ex_rt_q         <= '0;
            ex_uses_rs_q    <= 1'b0;
            ex_uses_rt_q    <= 1'b0;
            ex_dest_q       <= '0;
            ex_reg_write_q  <= 1'b0;
            ex_mem_read_q   <= 1'b0;
            mem_dest_q      <= '0;
            mem_reg_write_q <= 1'b0;
            wb_dest_q       <= '0;
            wb_reg_write_q  <= 1'b0;
            stall_count_q   <= '0;
        end else begin
            ex_rs_q         <= ex_rs_d;
            ex_rt_q         <= ex_rt_d;
            ex_uses_rs_q    <= ex_uses_rs_d;
            ex_uses_rt_q    <= ex_uses_rt_d;
            ex_dest_q       <= ex_dest_d;
            ex_reg_write_q  <= ex_reg_write_d;
            ex_mem_read_q   <= ex_mem_read_d;
            mem_dest_q      <= mem_dest_d;
            mem_reg_write_q <= mem_reg_write_d;
            wb_dest_q       <= wb_dest_d;
            wb_reg_write_q  <= wb_reg_write_d;
            stall_count_q   <= stall_count_d;
        end
    end

endmodule : hazard_forward_unit

// File: tb/tb_hazard_forward_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_forward_unit
//
// Directed vector table for the pipeline scenarios, hand sequences for
// counter saturation and reset during a stall, then random instruction
// streams compared against an instruction-history reference model.
// A narrow stall counter is used so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_hazard_forward_unit;

    localparam int REG_W   = 5;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] id_rs, id_rt, id_dest;
    logic             id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic             ex_branch_taken;
    logic [1:0]       fwd_a_sel, fwd_b_sel;
    logic             stall_if_id, flush_if_id, flush_id_ex;
    logic [CNT_W-1:0] stall_count;

    always #5 clk = ~clk;

    hazard_forward_unit #(
        .REG_W (REG_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_dest         (id_dest),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .fwd_a_sel       (fwd_a_sel),
        .fwd_b_sel       (fwd_b_sel),
        .stall_if_id     (stall_if_id),
        .flush_if_id     (flush_if_id),
        .flush_id_ex     (flush_id_ex),
        .stall_count     (stall_count)
    );

    typedef struct {
        logic [REG_W-1:0] rs, rt;
        logic             urs, urt;
        logic [REG_W-1:0] dest;
        logic             rw, mr;
    } instr_t;

    typedef struct {
        instr_t     ins;
        logic       br;
        logic [1:0] a, b;
        logic       st, fif, fie;
        int         cnt;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the instructions that entered EX over the last three
    // cycles (age 0 = EX, 1 = MEM, 2 = WB) and the stall tally.
    instr_t hist [3];
    int     m_cnt;
    bit     m_last_stall;
    instr_t nop_i;
    vec_t   dummy_v;

    function automatic instr_t mk(int rs, int rt, bit urs, bit urt,
                                  int dest, bit rw, bit mr);
        instr_t r;
        r.rs = REG_W'(rs); r.rt = REG_W'(rt);
        r.urs = urs; r.urt = urt;
        r.dest = REG_W'(dest); r.rw = rw; r.mr = mr;
        return r;
    endfunction

    function automatic vec_t mkv(instr_t ins, bit br, int a, int b,
                                 bit st, bit fif, bit fie, int cnt);
        vec_t v;
        v.ins = ins; v.br = br; v.a = 2'(a); v.b = 2'(b);
        v.st = st; v.fif = fif; v.fie = fie; v.cnt = cnt;
        return v;
    endfunction

    // Search older instructions from youngest to oldest for a real producer.
    function automatic logic [1:0] m_sel(logic [REG_W-1:0] src, logic uses);
        if (!uses) return 2'd0;
        for (int k = 1; k <= 2; k++) begin
            if (hist[k].rw && hist[k].dest != 0 && hist[k].dest == src)
                return 2'(k);
        end
        return 2'd0;
    endfunction

    function automatic bit m_load_use(instr_t id);
        if (!hist[0].mr || hist[0].dest == 0) return 1'b0;
        return (id.urs && id.rs == hist[0].dest) ||
               (id.urt && id.rt == hist[0].dest);
    endfunction

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // One cycle: drive ID fields, compare at the falling edge, advance the
    // model at the rising edge.
    task automatic step(input instr_t ins, input logic br, input logic rst,
                        input bit use_exp, input vec_t v, input string tag);
        logic [1:0] ea, eb;
        bit lu, est, efif, efie;
        id_rs = ins.rs; id_rt = ins.rt;
        id_uses_rs = ins.urs; id_uses_rt = ins.urt;
        id_dest = ins.dest; id_reg_write = ins.rw; id_mem_read = ins.mr;
        ex_branch_taken = br;
        reset = rst;
        @(negedge clk);
        ea   = m_sel(hist[0].rs, hist[0].urs);
        eb   = m_sel(hist[0].rt, hist[0].urt);
        lu   = m_load_use(ins);
        est  = lu && !br;
        efif = br;
        efie = lu || br;
        check({tag, " fwd_a_sel"},   32'(fwd_a_sel),   32'(ea));
        check({tag, " fwd_b_sel"},   32'(fwd_b_sel),   32'(eb));
        check({tag, " stall_if_id"}, 32'(stall_if_id), 32'(est));
        check({tag, " flush_if_id"}, 32'(flush_if_id), 32'(efif));
        check({tag, " flush_id_ex"}, 32'(flush_id_ex), 32'(efie));
        check({tag, " stall_count"}, 32'(stall_count), 32'(m_cnt));
        if (use_exp) begin
            check({tag, " tbl fwd_a_sel"},   32'(fwd_a_sel),   32'(v.a));
            check({tag, " tbl fwd_b_sel"},   32'(fwd_b_sel),   32'(v.b));
            check({tag, " tbl stall_if_id"}, 32'(stall_if_id), 32'(v.st));
            check({tag, " tbl flush_if_id"}, 32'(flush_if_id), 32'(v.fif));
            check({tag, " tbl flush_id_ex"}, 32'(flush_id_ex), 32'(v.fie));
            check({tag, " tbl stall_count"}, 32'(stall_count), 32'(v.cnt));
        end
        @(posedge clk);
        if (rst) begin
            for (int k = 0; k < 3; k++) hist[k] = nop_i;
            m_cnt = 0;
            m_last_stall = 1'b0;
        end else begin
            if (est && m_cnt < CNT_MAX) m_cnt++;
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = efie ? nop_i : ins;
            m_last_stall = est;
        end
        #1;
    endtask

    vec_t tbl [19];

    initial begin
        instr_t add3, sub3, or3, lw5, add5, p0, c0, lw4, add4, cur;
        logic   br, rst;

        nop_i = mk(0, 0, 0, 0, 0, 0, 0);
        dummy_v = mkv(nop_i, 0, 0, 0, 0, 0, 0, 0);
        add3 = mk(1, 2, 1, 1, 3, 1, 0);
        sub3 = mk(3, 4, 1, 1, 5, 1, 0);
        or3  = mk(6, 3, 1, 1, 7, 1, 0);
        lw5  = mk(1, 0, 1, 0, 5, 1, 1);
        add5 = mk(5, 2, 1, 1, 6, 1, 0);
        p0   = mk(1, 2, 1, 1, 0, 1, 0);
        c0   = mk(0, 0, 1, 1, 8, 1, 0);
        lw4  = mk(1, 0, 1, 0, 4, 1, 1);
        add4 = mk(4, 4, 1, 1, 9, 1, 0);

        //              ins   br  a  b  st fif fie cnt
        tbl[0]  = mkv(nop_i, 0, 0, 0, 0, 0, 0, 0);  // reset state
        tbl[1]  = mkv(add3,  0, 0, 0, 0, 0, 0, 0);  // add r3
        tbl[2]  = mkv(sub3,  0, 0, 0, 0, 0, 0, 0);  // sub rs=r3
        tbl[3]  = mkv(nop_i, 0, 1, 0, 0, 0, 0, 0);  // sub in EX: EX/MEM fwd
        tbl[4]  = mkv(add3,  0, 0, 0, 0, 0, 0, 0);  // add r3
        tbl[5]  = mkv(nop_i, 0, 0, 0, 0, 0, 0, 0);  // nop
        tbl[6]  = mkv(or3,   0, 0, 0, 0, 0, 0, 0);  // or rt=r3
        tbl[7]  = mkv(nop_i, 0, 0, 2, 0, 0, 0, 0);  // or in EX: MEM/WB fwd
        tbl[8]  = mkv(lw5,   0, 0, 0, 0, 0, 0, 0);  // lw r5
        tbl[9]  = mkv(add5,  0, 0, 0, 1, 0, 1, 0);  // load-use stall
        tbl[10] = mkv(add5,  0, 0, 0, 0, 0, 0, 1);  // re-presented, bubble in EX
        tbl[11] = mkv(nop_i, 0, 2, 0, 0, 0, 0, 1);  // add in EX: from WB
        tbl[12] = mkv(p0,    0, 0, 0, 0, 0, 0, 1);  // writes r0
        tbl[13] = mkv(c0,    0, 0, 0, 0, 0, 0, 1);  // reads r0
        tbl[14] = mkv(nop_i, 0, 0, 0, 0, 0, 0, 1);  // r0 never forwards
        tbl[15] = mkv(nop_i, 0, 0, 0, 0, 0, 0, 1);
        tbl[16] = mkv(lw4,   0, 0, 0, 0, 0, 0, 1);  // lw r4
        tbl[17] = mkv(add4,  1, 0, 0, 0, 1, 1, 1);  // load-use + branch
        tbl[18] = mkv(nop_i, 0, 0, 0, 0, 0, 0, 1);  // no count, no stall

        // Bring-up reset (outputs undefined before it, so not compared).
        reset = 1'b1; ex_branch_taken = 1'b0;
        id_rs = '0; id_rt = '0; id_dest = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_reg_write = 1'b0; id_mem_read = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) hist[k] = nop_i;
        m_cnt = 0;
        m_last_stall = 1'b0;

        for (int i = 0; i < 19; i++)
            step(tbl[i].ins, tbl[i].br, 1'b0, 1'b1, tbl[i], $sformatf("vec%0d", i));

        // Drive the counter past all-ones; it must stick there.
        for (int i = 0; i < CNT_MAX + 2; i++) begin
            step(lw5, 1'b0, 1'b0, 1'b0, dummy_v, "sat lw");
            step(add5, 1'b0, 1'b0, 1'b1,
                 mkv(add5, 0, 0, 0, 1, 0, 1, (1 + i > CNT_MAX) ? CNT_MAX : 1 + i),
                 $sformatf("sat stall%0d", i));
            step(add5, 1'b0, 1'b0, 1'b0, dummy_v, "sat held");
        end
        step(nop_i, 1'b0, 1'b0, 1'b1,
             mkv(nop_i, 0, 2, 0, 0, 0, 0, CNT_MAX), "sat final");

        // Reset asserted during the stall cycle: nothing survives it.
        step(lw5, 1'b0, 1'b0, 1'b0, dummy_v, "rst lw");
        step(add5, 1'b0, 1'b1, 1'b1,
             mkv(add5, 0, 0, 0, 1, 0, 1, CNT_MAX), "rst stall");
        step(add5, 1'b0, 1'b0, 1'b1,
             mkv(add5, 0, 0, 0, 0, 0, 0, 0), "rst after");
        step(nop_i, 1'b0, 1'b0, 1'b1,
             mkv(nop_i, 0, 0, 0, 0, 0, 0, 0), "rst clean");

        // Random instruction streams over a small register set so hazards
        // are frequent; a stalled instruction is re-presented like a real
        // IF/ID would do.
        cur = nop_i;
        for (int i = 0; i < 3000; i++) begin
            if (!m_last_stall) begin
                cur.rs   = REG_W'($urandom_range(0, 3));
                cur.rt   = REG_W'($urandom_range(0, 3));
                cur.urs  = 1'($urandom_range(0, 1));
                cur.urt  = 1'($urandom_range(0, 1));
                cur.dest = REG_W'($urandom_range(0, 3));
                cur.mr   = ($urandom_range(0, 2) == 0);
                cur.rw   = cur.mr | 1'($urandom_range(0, 1));
            end
            br  = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 99) == 0);
            step(cur, br, rst, 1'b0, dummy_v, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_hazard_forward_unit
